// File: rtl/cdb_if.sv
// Common Data Bus interface: FU results and branch controls in, broadcast lanes and stalls out.
// The broadcaster's optional round-robin selection is enabled with CDB_RR_EN.
`ifndef N
`define N 2
`endif
`ifndef NUM_FU_ALU
`define NUM_FU_ALU 1
`endif
`ifndef NUM_FU_MULT
`define NUM_FU_MULT 1
`endif
`ifndef NUM_FU_LD
`define NUM_FU_LD 1
`endif
`ifndef NUM_FU_STORE
`define NUM_FU_STORE 0
`endif
`ifndef NUM_FU_BR
`define NUM_FU_BR 1
`endif
`ifndef PREG_W
`define PREG_W 6
`endif
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef BR_W
`define BR_W 4
`endif
`ifndef BR_SQUASH
`define BR_SQUASH 2'd1
`endif
`ifndef BR_CLEAR
`define BR_CLEAR 2'd2
`endif

interface cdb_if #(
  parameter int N      = `N,
  parameter int NUM_FU = `NUM_FU_ALU + `NUM_FU_MULT + `NUM_FU_LD + `NUM_FU_STORE + `NUM_FU_BR,
  parameter int PREG_W = `PREG_W,
  parameter int DATA_W = `DATA_W,
  parameter int BR_W   = `BR_W
);
  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] reg_idx;
    logic [DATA_W-1:0] value;
  } cdb_packet_t;

  cdb_packet_t [NUM_FU-1:0]          fu_in;
  logic [NUM_FU-1:0][BR_W-1:0]       fu_bmask;
  logic [BR_W-1:0]                   br_id;
  logic [1:0]                        br_task;
  logic [NUM_FU-1:0]                 fu_stall;
  cdb_packet_t [N-1:0]               cdb_out;
  logic [$clog2(N+1)-1:0]            num_broadcast;

  // master is the broadcaster; slave is the FU / consumer side
  modport master (
    input  fu_in, fu_bmask, br_id, br_task,
    output fu_stall, cdb_out, num_broadcast
  );

  modport slave (
    output fu_in, fu_bmask, br_id, br_task,
    input  fu_stall, cdb_out, num_broadcast
  );
endinterface

// File: rtl/cdb.sv
// cdb: selects up to N completed FU results per cycle onto a registered broadcast bus.
// Define CDB_RR_EN for round-robin selection; otherwise FU 0 has fixed highest priority.
`ifndef N
`define N 2
`endif
`ifndef NUM_FU_ALU
`define NUM_FU_ALU 1
`endif
`ifndef NUM_FU_MULT
`define NUM_FU_MULT 1
`endif
`ifndef NUM_FU_LD
`define NUM_FU_LD 1
`endif
`ifndef NUM_FU_STORE
`define NUM_FU_STORE 0
`endif
`ifndef NUM_FU_BR
`define NUM_FU_BR 1
`endif
`ifndef PREG_W
`define PREG_W 6
`endif
`ifndef DATA_W
`define DATA_W 32
`endif
`ifndef BR_W
`define BR_W 4
`endif
`ifndef BR_SQUASH
`define BR_SQUASH 2'd1
`endif
`ifndef BR_CLEAR
`define BR_CLEAR 2'd2
`endif

module cdb #(
  parameter int N      = `N,
  parameter int NUM_FU = `NUM_FU_ALU + `NUM_FU_MULT + `NUM_FU_LD + `NUM_FU_STORE + `NUM_FU_BR,
  parameter int PREG_W = `PREG_W,
  parameter int DATA_W = `DATA_W,
  parameter int BR_W   = `BR_W
) (
  input  logic  clock,
  input  logic  reset,
  cdb_if.master bus
);
  localparam int NB_W = $clog2(N + 1);

  typedef struct packed {
    logic              valid;
    logic [PREG_W-1:0] reg_idx;
    logic [DATA_W-1:0] value;
  } pkt_t;

  logic [NUM_FU-1:0]            hold_valid_q, hold_valid_d;
  pkt_t [NUM_FU-1:0]            hold_pkt_q, hold_pkt_d;
  logic [NUM_FU-1:0][BR_W-1:0]  hold_bmask_q, hold_bmask_d;
  pkt_t [N-1:0]                 cdb_q, cdb_d;
  logic [NB_W-1:0]              nb_q, nb_d;

  logic [NUM_FU-1:0]            cand_valid;
  pkt_t [NUM_FU-1:0]            cand_pkt;
  logic [NUM_FU-1:0][BR_W-1:0]  cand_bmask;
  logic [NUM_FU-1:0]            survive;
  logic [NUM_FU-1:0]            grant;
  logic                         is_squash;
  logic                         is_clear;
  int                           start_idx;

`ifdef CDB_RR_EN
  localparam int PTR_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
  assign start_idx = int'(rr_ptr_q);
`else
  assign start_idx = 0;
`endif

  assign is_squash = (bus.br_task == `BR_SQUASH);
  assign is_clear  = (bus.br_task == `BR_CLEAR);

  // A held result takes precedence; a stalled FU's input is not looked at.
  always_comb begin
    cand_valid = '0;
    cand_pkt   = '0;
    cand_bmask = '0;
    survive    = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      if (hold_valid_q[i]) begin
        cand_valid[i] = 1'b1;
        cand_pkt[i]   = hold_pkt_q[i];
        cand_bmask[i] = hold_bmask_q[i];
      end else begin
        cand_valid[i] = bus.fu_in[i].valid;
        cand_pkt[i]   = pkt_t'(bus.fu_in[i]);
        cand_bmask[i] = bus.fu_bmask[i];
      end
      survive[i] = cand_valid[i] & ~(is_squash & (|(cand_bmask[i] & bus.br_id)));
    end
  end

  // Scan from the start index, wrapping, and pack grants into lanes from lane 0.
  always_comb begin
    int cnt;
    int idx;
`ifdef CDB_RR_EN
    int last;
    last = 0;
`endif
    cnt   = 0;
    idx   = 0;
    grant = '0;
    cdb_d = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = start_idx + k;
      if (idx >= NUM_FU) idx = idx - NUM_FU;
      for (int j = 0; j < NUM_FU; j++) begin
        if (j == idx && survive[j] && cnt < N) begin
          grant[j] = 1'b1;
          for (int l = 0; l < N; l++) begin
            if (l == cnt) cdb_d[l] = cand_pkt[j];
          end
          cnt = cnt + 1;
`ifdef CDB_RR_EN
          last = j;
`endif
        end
      end
    end
    nb_d = NB_W'(cnt);
`ifdef CDB_RR_EN
    rr_ptr_d = rr_ptr_q;
    if (cnt > 0) rr_ptr_d = (last + 1 >= NUM_FU) ? '0 : PTR_W'(last + 1);
`endif
  end

  // Surviving but ungranted candidates stay (or become) held; CLEAR strips the resolved bit.
  always_comb begin
    hold_valid_d = '0;
    hold_pkt_d   = hold_pkt_q;
    hold_bmask_d = hold_bmask_q;
    for (int i = 0; i < NUM_FU; i++) begin
      hold_valid_d[i] = survive[i] & ~grant[i];
      if (survive[i] & ~grant[i]) begin
        hold_pkt_d[i]   = cand_pkt[i];
        hold_bmask_d[i] = is_clear ? (cand_bmask[i] & ~bus.br_id) : cand_bmask[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hold_valid_q <= '0;
      hold_pkt_q   <= '0;
      hold_bmask_q <= '0;
      cdb_q        <= '0;
      nb_q         <= '0;
`ifdef CDB_RR_EN
      rr_ptr_q     <= '0;
`endif
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_pkt_q   <= hold_pkt_d;
      hold_bmask_q <= hold_bmask_d;
      cdb_q        <= cdb_d;
      nb_q         <= nb_d;
`ifdef CDB_RR_EN
      rr_ptr_q     <= rr_ptr_d;
`endif
    end
  end

  assign bus.fu_stall      = hold_valid_q;
  assign bus.cdb_out       = cdb_q;
  assign bus.num_broadcast = nb_q;

  a_nb_bound: assert property (@(posedge clock) disable iff (reset) (nb_q <= NB_W'(N)));
  a_lane0_valid: assert property (@(posedge clock) disable iff (reset)
                                  (cdb_q[0].valid == (nb_q != '0)));
endmodule

// File: tb/tb_cdb.sv
// Bench for cdb: two instances (N=2 and N=1, four FUs) against a queue-based model, plus directed scenarios.
module tb_cdb;
  localparam int NF  = 4;
  localparam int PW  = 6;
  localparam int DW  = 8;
  localparam int BW  = 4;
  localparam int PKW = 1 + PW + DW;
  localparam logic [1:0] T_SQ = 2'd1;
  localparam logic [1:0] T_CL = 2'd2;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  cdb_if #(.N(2), .NUM_FU(NF), .PREG_W(PW), .DATA_W(DW), .BR_W(BW)) bus0();
  cdb_if #(.N(1), .NUM_FU(NF), .PREG_W(PW), .DATA_W(DW), .BR_W(BW)) bus1();

  cdb #(.N(2), .NUM_FU(NF), .PREG_W(PW), .DATA_W(DW), .BR_W(BW)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0.master));
  cdb #(.N(1), .NUM_FU(NF), .PREG_W(PW), .DATA_W(DW), .BR_W(BW)) dut1 (
    .clock(clock), .reset(reset), .bus(bus1.master));

  // stimulus per instance
  bit         dv [2][NF];
  int         dr [2][NF];
  int         dd [2][NF];
  int         dm [2][NF];
  logic [BW-1:0] br_id   = '0;
  logic [1:0]    br_task = '0;

  // model state
  bit   mv [2][NF];
  int   mr [2][NF];
  int   md [2][NF];
  int   mm [2][NF];
  int   mptr [2];
  logic [PKW-1:0] ep [2][2];
  int   enb [2];
  bit   started = 0;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [PKW-1:0] pk(input bit v, input int r, input int d);
    return {v, PW'(r), DW'(d)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step(input int d, input int n);
    bit cv [NF];
    int cr [NF];
    int cdv [NF];
    int cm [NF];
    bit sq [NF];
    bit g [NF];
    int order [$];
    int ng;
    int start;
    int i;
    if (reset) begin
      for (int f = 0; f < NF; f++) mv[d][f] = 0;
      mptr[d] = 0;
      ep[d][0] = '0;
      ep[d][1] = '0;
      enb[d] = 0;
      return;
    end
    for (int f = 0; f < NF; f++) begin
      if (mv[d][f]) begin
        cv[f] = 1; cr[f] = mr[d][f]; cdv[f] = md[d][f]; cm[f] = mm[d][f];
      end else begin
        cv[f] = dv[d][f]; cr[f] = dr[d][f]; cdv[f] = dd[d][f]; cm[f] = dm[d][f];
      end
      sq[f] = cv[f] && (br_task == T_SQ) && ((cm[f] & int'(br_id)) != 0);
      g[f]  = 0;
    end
`ifdef CDB_RR_EN
    start = mptr[d];
`else
    start = 0;
`endif
    for (int k = 0; k < NF; k++) begin
      i = (start + k) % NF;
      if (cv[i] && !sq[i]) order.push_back(i);
    end
    ng = (order.size() < n) ? order.size() : n;
    for (int l = 0; l < 2; l++) begin
      ep[d][l] = '0;
      if (l < ng) ep[d][l] = pk(1'b1, cr[order[l]], cdv[order[l]]);
    end
    for (int l = 0; l < ng; l++) g[order[l]] = 1;
    for (int f = 0; f < NF; f++) begin
      mv[d][f] = cv[f] && !sq[f] && !g[f];
      mr[d][f] = cr[f];
      md[d][f] = cdv[f];
      mm[d][f] = (br_task == T_CL) ? (cm[f] & ~int'(br_id)) : cm[f];
    end
    if (ng > 0) mptr[d] = (order[ng-1] + 1) % NF;
    enb[d] = ng;
  endtask

  always @(posedge clock) begin
    model_step(0, 2);
    model_step(1, 1);
    started = 1;
  end

  always @(negedge clock) begin
    logic [NF-1:0] es0, es1;
    if (started) begin
      for (int f = 0; f < NF; f++) begin
        es0[f] = mv[0][f];
        es1[f] = mv[1][f];
      end
      chk("dut0_lane0", bus0.cdb_out[0], ep[0][0]);
      chk("dut0_lane1", bus0.cdb_out[1], ep[0][1]);
      chk("dut0_num_broadcast", bus0.num_broadcast, enb[0]);
      chk("dut0_fu_stall", bus0.fu_stall, es0);
      chk("dut1_lane0", bus1.cdb_out[0], ep[1][0]);
      chk("dut1_num_broadcast", bus1.num_broadcast, enb[1]);
      chk("dut1_fu_stall", bus1.fu_stall, es1);
    end
  end

  task automatic push();
    for (int f = 0; f < NF; f++) begin
      bus0.fu_in[f]    = pk(dv[0][f], dr[0][f], dd[0][f]);
      bus0.fu_bmask[f] = BW'(dm[0][f]);
      bus1.fu_in[f]    = pk(dv[1][f], dr[1][f], dd[1][f]);
      bus1.fu_bmask[f] = BW'(dm[1][f]);
    end
    bus0.br_id = br_id;  bus0.br_task = br_task;
    bus1.br_id = br_id;  bus1.br_task = br_task;
  endtask

  task automatic step();
    push();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_in();
    for (int d = 0; d < 2; d++)
      for (int f = 0; f < NF; f++) begin
        dv[d][f] = 0; dr[d][f] = 0; dd[d][f] = 0; dm[d][f] = 0;
      end
    br_id = '0;
    br_task = '0;
  endtask

  task automatic idle_free();
    for (int d = 0; d < 2; d++)
      for (int f = 0; f < NF; f++)
        if (!mv[d][f]) dv[d][f] = 0;
  endtask

  task automatic set_fu(input int d, input int f, input int r, input int m);
    dv[d][f] = 1; dr[d][f] = r; dd[d][f] = r + 100; dm[d][f] = m;
  endtask

  task automatic do_reset();
    clr_in();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic load_four(input int m3);
    for (int d = 0; d < 2; d++)
      for (int f = 0; f < NF; f++) set_fu(d, f, 5 + f, (f == 3) ? m3 : 0);
  endtask

  int cnt;
  int n0, n1, alts, nbc;
  bit src, prev_src;
  logic [PKW-1:0] v1;

  initial begin
    do_reset();
    step();

    // single result, no contention
    for (int d = 0; d < 2; d++) set_fu(d, 2, 17, 0);
    step();
    chk("single_lane0", bus0.cdb_out[0], pk(1'b1, 17, 117));
    chk("single_num", bus0.num_broadcast, 1);
    chk("single_stall", bus0.fu_stall, 4'b0000);
    idle_free();
    step();

    // four-way contention on the two-lane instance
    do_reset();
    load_four(0);
    step();
    chk("cont1_lane0", bus0.cdb_out[0], pk(1'b1, 5, 105));
    chk("cont1_lane1", bus0.cdb_out[1], pk(1'b1, 6, 106));
    chk("cont1_stall", bus0.fu_stall, 4'b1100);
    idle_free();
    step();
    chk("cont2_lane0", bus0.cdb_out[0], pk(1'b1, 7, 107));
    chk("cont2_lane1", bus0.cdb_out[1], pk(1'b1, 8, 108));
    chk("cont2_stall", bus0.fu_stall, 4'b0000);
    repeat (4) step();

    // reset while results are held
    do_reset();
    load_four(0);
    step();
    idle_free();
    reset = 1'b1;
    step();
    chk("rst_num0", bus0.num_broadcast, 0);
    chk("rst_lane0", bus0.cdb_out[0], 0);
    chk("rst_stall0", bus0.fu_stall, 4'b0000);
    chk("rst_stall1", bus1.fu_stall, 4'b0000);
    reset = 1'b0;
    clr_in();
    cnt = 0;
    repeat (4) begin
      step();
      cnt += int'(bus0.num_broadcast) + int'(bus1.num_broadcast);
    end
    chk("rst_no_bcast", cnt, 0);

    // squash of a held result
    do_reset();
    load_four(4'b0010);
    step();
    idle_free();
    br_task = T_SQ;
    br_id   = 4'b0010;
    step();
    chk("sq_stall", bus0.fu_stall, 4'b0000);
    chk("sq_lane0", bus0.cdb_out[0], pk(1'b1, 7, 107));
    chk("sq_num", bus0.num_broadcast, 1);
    br_task = '0;
    br_id   = '0;
    cnt = 0;
    repeat (5) begin
      idle_free();
      step();
      if (bus0.cdb_out[0] == pk(1'b1, 8, 108) || bus0.cdb_out[1] == pk(1'b1, 8, 108) ||
          bus1.cdb_out[0] == pk(1'b1, 8, 108)) cnt++;
    end
    chk("sq_never_bcast", cnt, 0);

    // CLEAR then SQUASH on a held result (single-lane instance)
    do_reset();
    for (int d = 0; d < 2; d++) begin
      set_fu(d, 0, 10, 0);
      set_fu(d, 1, 11, 4'b0110);
    end
    step();
    idle_free();
    for (int d = 0; d < 2; d++) if (!mv[d][0]) set_fu(d, 0, 12, 0);
    br_task = T_CL;
    br_id   = 4'b0100;
    step();
    cnt = 0;
    v1 = bus1.cdb_out[0];
    if (v1 == pk(1'b1, 11, 111)) cnt++;
`ifdef CDB_RR_EN
    chk("clr_edge_b", v1, pk(1'b1, 11, 111));
`else
    chk("clr_edge_b", v1, pk(1'b1, 12, 112));
`endif
    idle_free();
    br_task = T_SQ;
    br_id   = 4'b0100;
    step();
    v1 = bus1.cdb_out[0];
    if (v1 == pk(1'b1, 11, 111)) cnt++;
`ifdef CDB_RR_EN
    chk("clr_edge_c", v1, pk(1'b1, 12, 112));
`else
    chk("clr_edge_c", v1, pk(1'b1, 11, 111));
`endif
    br_task = '0;
    br_id   = '0;
    repeat (3) begin
      idle_free();
      step();
      v1 = bus1.cdb_out[0];
      if (v1 == pk(1'b1, 11, 111)) cnt++;
    end
    chk("clr_sq_once", cnt, 1);

    // FU 0 and FU 1 saturating the single-lane instance
    do_reset();
    n0 = 0; n1 = 0; alts = 0; nbc = 0; prev_src = 0;
    for (int k = 0; k < 8; k++) begin
      for (int d = 0; d < 2; d++) begin
        if (!mv[d][0]) set_fu(d, 0, 20 + k, 0);
        if (!mv[d][1]) set_fu(d, 1, 40 + k, 0);
      end
      step();
      v1 = bus1.cdb_out[0];
      if (v1[PKW-1]) begin
        src = (v1[DW +: PW] >= 6'd40);
        if (nbc > 0 && src != prev_src) alts++;
        if (src) n1++; else n0++;
        prev_src = src;
        nbc++;
      end
    end
`ifdef CDB_RR_EN
    chk("rr_alternations", alts, 7);
    chk("rr_broadcasts", nbc, 8);
`else
    chk("fixed_fu1_count", n1, 0);
    chk("fixed_fu0_count", n0, 8);
`endif

    // randomized traffic
    clr_in();
    for (int c = 0; c < 3000; c++) begin
      int r;
      reset = ($urandom_range(0, 99) == 0);
      r = $urandom_range(0, 9);
      br_task = (r == 0) ? T_SQ : (r == 1) ? T_CL : (r == 2) ? 2'd3 : 2'd0;
      br_id   = BW'(1 << $urandom_range(0, BW - 1));
      for (int d = 0; d < 2; d++)
        for (int f = 0; f < NF; f++)
          if (!mv[d][f]) begin
            dv[d][f] = ($urandom_range(0, 2) != 0);
            dr[d][f] = $urandom_range(0, 63);
            dd[d][f] = $urandom_range(0, 255);
            dm[d][f] = $urandom_range(0, 15);
          end
      step();
    end
    reset = 1'b0;
    clr_in();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
